// File: rtl/pipe_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : pipe_scoreboard
// Purpose  : Hazard and bypass-control unit for the in-order MCU pipeline.
//            Tracks in-flight destination registers across NSTAGE post-decode
//            stages (stage 1 = EXE, stage NSTAGE = WB), selects the bypass
//            source for each decode operand, stalls decode on load-use and
//            unresolved dependencies, and holds EXE while a multi-cycle
//            multiply/divide op occupies stage 1.
//
// Parameters
//   NSTAGE   : post-decode stages tracked (2..6)
//   LOAD_STG : first stage whose output carries load data (2..NSTAGE)
//   MD_LAT   : cycles an M/D op occupies stage 1, first cycle included (1..64)
//   SW       : derived select width, $clog2(NSTAGE+1)
//
// Ports
//   clk, resetn                 : rising-edge clock, async active-low reset
//   issue_valid_i               : decode holds a valid instruction
//   dst_en_i, rd_i              : decoded destination write enable / index
//   rs1_i, rs2_i                : decoded source indices
//   rs1_en_i, rs2_en_i          : source actually read
//   is_load_i, is_md_i          : decoded instruction class
//   flush_i                     : redirect from EXE, kills decode instruction
//   stall_o                     : hold fetch/decode this cycle
//   src1_sel_o, src2_sel_o      : 0 = regfile, k = bypass from stage k output
//   hold_e_o                    : M/D op occupying stage 1, EXE must not advance
//   busy_o                      : M/D counter non-zero
//
// Configuration macro
//   SCB_FWD_EN : defined   -> full bypass network
//                undefined -> selects tied to 0, any in-flight match stalls
//
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_scoreboard #(
   parameter int  NSTAGE   = 3,
   parameter int  LOAD_STG = 2,
   parameter int  MD_LAT   = 4,
   localparam int SW       = $clog2(NSTAGE + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          issue_valid_i,
   input  logic          dst_en_i,
   input  logic [4:0]    rd_i,
   input  logic [4:0]    rs1_i,
   input  logic [4:0]    rs2_i,
   input  logic          rs1_en_i,
   input  logic          rs2_en_i,
   input  logic          is_load_i,
   input  logic          is_md_i,
   input  logic          flush_i,
   output logic          stall_o,
   output logic [SW-1:0] src1_sel_o,
   output logic [SW-1:0] src2_sel_o,
   output logic          hold_e_o,
   output logic          busy_o
);

   // Counter only ever holds MD_LAT-1 (max 63)
   localparam int          CW      = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
   localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT - 1);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       dst_en;
      logic       is_load;
      logic       is_md;
   } entry_t;

   entry_t         stg_q [1:NSTAGE];
   logic [CW-1:0]  md_cnt;

   logic           hold;
   logic           busy;
   logic           accept;
   logic [1:0]     op_stall;
   logic [1:0][4:0] src;
   logic [1:0]     src_en;
   logic [1:0][SW-1:0] sel;
   entry_t         new_entry;
   logic           unused_fields;

   assign src    = {rs2_i, rs1_i};
   assign src_en = {rs2_en_i, rs1_en_i};

   // The counter is only ever loaded by an M/D entry entering stage 1 and is
   // cleared together with the stages, so the stage-1 is_md bit and a non-zero
   // count always coincide; qualifying with both keeps the hold tied to the op.
   assign busy = (md_cnt != '0);
   assign hold = busy & stg_q[1].is_md;

   //---------------------------------------------------------------------------
   // Operand resolution
   //---------------------------------------------------------------------------
`ifdef SCB_FWD_EN
   logic [1:0][SW-1:0] ysel;
   logic [1:0]         yload;
   logic [1:0]         any_match;

   always_comb begin
      ysel      = '0;
      yload     = '0;
      any_match = '0;
      sel       = '0;
      op_stall  = '0;
      for (int s = 0; s < 2; s++) begin
         // Scan oldest to youngest so the lowest matching stage wins.
         for (int k = NSTAGE; k >= 1; k--) begin
            if (src_en[s] && (src[s] != 5'd0) && stg_q[k].valid &&
                stg_q[k].dst_en && (stg_q[k].rd == src[s])) begin
               ysel[s]      = SW'(k);
               yload[s]     = stg_q[k].is_load;
               any_match[s] = 1'b1;
            end
         end
         // Load data is not available before LOAD_STG; a stage-1 producer
         // that is still being held has not produced its result yet.
         op_stall[s] = any_match[s] &&
                       ((yload[s] && (ysel[s] < SW'(LOAD_STG))) ||
                        ((ysel[s] == SW'(1)) && hold));
         sel[s]      = op_stall[s] ? '0 : ysel[s];
      end
   end
`else
   logic [1:0] any_match;

   always_comb begin
      any_match = '0;
      sel       = '0;
      for (int s = 0; s < 2; s++) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            if (src_en[s] && (src[s] != 5'd0) && stg_q[k].valid &&
                stg_q[k].dst_en && (stg_q[k].rd == src[s])) begin
               any_match[s] = 1'b1;
            end
         end
      end
      // Without bypass the consumer waits until the producer has written the
      // regfile, i.e. has left stage NSTAGE.
      op_stall = any_match;
   end
`endif

   // Fields carried for completeness but not consumed by this configuration.
   always_comb begin
      unused_fields = 1'b0;
      for (int k = 2; k <= NSTAGE; k++) begin
         unused_fields = unused_fields ^ stg_q[k].is_md;
      end
`ifndef SCB_FWD_EN
      unused_fields = unused_fields ^ is_load_i;
      for (int k = 1; k <= NSTAGE; k++) begin
         unused_fields = unused_fields ^ stg_q[k].is_load;
      end
`endif
   end

   //---------------------------------------------------------------------------
   // Stall / issue
   //---------------------------------------------------------------------------
   // The last cycle an M/D op spends in stage 1 is the one with the counter
   // at zero, where hold is already low; so every hold cycle stalls a valid
   // decode instruction, since stage 1 cannot accept it.
   assign stall_o = (|op_stall) | (issue_valid_i & hold);
   assign accept  = issue_valid_i & ~stall_o & ~flush_i;

   always_comb begin
      new_entry         = '0;
      new_entry.valid   = 1'b1;
      new_entry.rd      = rd_i;
      new_entry.dst_en  = dst_en_i;
      new_entry.is_load = is_load_i;
      new_entry.is_md   = is_md_i;
   end

   //---------------------------------------------------------------------------
   // Stage tracking and M/D countdown
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            stg_q[k] <= '0;
         end
         md_cnt <= '0;
      end else begin
         if (!hold) begin
            stg_q[1] <= accept ? new_entry : '0;
         end
         // While stage 1 is held, a bubble enters stage 2.
         stg_q[2] <= hold ? '0 : stg_q[1];
         for (int k = 3; k <= NSTAGE; k++) begin
            stg_q[k] <= stg_q[k-1];
         end

         if (accept && is_md_i) begin
            md_cnt <= MD_INIT;
         end else if (busy) begin
            md_cnt <= md_cnt - 1'b1;
         end
      end
   end

   assign src1_sel_o = sel[0];
   assign src2_sel_o = sel[1];
   assign hold_e_o   = hold;
   assign busy_o     = busy;

endmodule

`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_scoreboard
// Purpose  : Directed self-checking bench for pipe_scoreboard (NSTAGE=3,
//            LOAD_STG=2, MD_LAT=4). Expected values follow the build mode
//            selected by SCB_FWD_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_scoreboard;

   localparam int NSTAGE   = 3;
   localparam int LOAD_STG = 2;
   localparam int MD_LAT   = 4;
   localparam int SW       = $clog2(NSTAGE + 1);
`ifdef SCB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          issue_valid_i = 1'b0;
   logic          dst_en_i = 1'b0;
   logic [4:0]    rd_i = '0;
   logic [4:0]    rs1_i = '0;
   logic [4:0]    rs2_i = '0;
   logic          rs1_en_i = 1'b0;
   logic          rs2_en_i = 1'b0;
   logic          is_load_i = 1'b0;
   logic          is_md_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          stall_o;
   logic [SW-1:0] src1_sel_o;
   logic [SW-1:0] src2_sel_o;
   logic          hold_e_o;
   logic          busy_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   pipe_scoreboard #(
      .NSTAGE   (NSTAGE),
      .LOAD_STG (LOAD_STG),
      .MD_LAT   (MD_LAT)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .issue_valid_i (issue_valid_i),
      .dst_en_i      (dst_en_i),
      .rd_i          (rd_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .rs1_en_i      (rs1_en_i),
      .rs2_en_i      (rs2_en_i),
      .is_load_i     (is_load_i),
      .is_md_i       (is_md_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .src1_sel_o    (src1_sel_o),
      .src2_sel_o    (src2_sel_o),
      .hold_e_o      (hold_e_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic decode(input logic v, input logic d, input logic [4:0] rd,
                         input logic [4:0] s1, input logic e1,
                         input logic [4:0] s2, input logic e2,
                         input logic ld, input logic md);
      issue_valid_i = v;
      dst_en_i      = d;
      rd_i          = rd;
      rs1_i         = s1;
      rs1_en_i      = e1;
      rs2_i         = s2;
      rs2_en_i      = e2;
      is_load_i     = ld;
      is_md_i       = md;
   endtask

   task automatic idle();
      decode(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      flush_i = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (NSTAGE + 2) tick();
   endtask

   // Counts stall cycles (and hold cycles among them) for the decode
   // instruction currently presented; returns at the first non-stall cycle.
   task automatic measure(output int stalls, output int holds);
      stalls = 0;
      holds  = 0;
      #1;
      while (stall_o && stalls < 20) begin
         if (hold_e_o) holds++;
         stalls++;
         tick();
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int ho;

      // ---------------- reset with random inputs ----------------
      repeat (3) begin
         @(posedge clk);
         #1;
         issue_valid_i = 1'($urandom);
         dst_en_i      = 1'($urandom);
         rd_i          = 5'($urandom);
         rs1_i         = 5'($urandom);
         rs2_i         = 5'($urandom);
         rs1_en_i      = 1'($urandom);
         rs2_en_i      = 1'($urandom);
         is_load_i     = 1'($urandom);
         is_md_i       = 1'($urandom);
         flush_i       = 1'($urandom);
      end
      #1;
      check("rst_stall", 32'(stall_o), 0);
      check("rst_sel1",  32'(src1_sel_o), 0);
      check("rst_sel2",  32'(src2_sel_o), 0);
      check("rst_hold",  32'(hold_e_o), 0);
      check("rst_busy",  32'(busy_o), 0);
      idle();
      #2;
      resetn = 1'b1;
      tick();

      // ---------------- back-to-back RAW ----------------
      decode(1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0);
      #1;
      check("b2b_prod_stall", 32'(stall_o), 0);
      tick();
      decode(1, 1, 5'd6, 5'd5, 1, 5'd1, 1, 0, 0);
      measure(st, ho);
      check("b2b_stalls", 32'(st), FWD ? 0 : NSTAGE);
      check("b2b_sel1", 32'(src1_sel_o), FWD ? 1 : 0);
      check("b2b_sel2", 32'(src2_sel_o), 0);
      drain();

      // ---------------- one-slot spacing, then aged out ----------------
      decode(1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      idle();
      tick();
      decode(1, 1, 5'd6, 5'd5, 1, 5'd0, 0, 0, 0);
      measure(st, ho);
      check("gap_stalls", 32'(st), FWD ? 0 : NSTAGE - 1);
      check("gap_sel1", 32'(src1_sel_o), FWD ? 2 : 0);
      idle();
      repeat (3) tick();
      decode(1, 1, 5'd6, 5'd5, 1, 5'd0, 0, 0, 0);
      #1;
      check("aged_sel1", 32'(src1_sel_o), 0);
      check("aged_stall", 32'(stall_o), 0);
      drain();

      // ---------------- load-use ----------------
      decode(1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 1, 0);
      tick();
      decode(1, 1, 5'd8, 5'd7, 1, 5'd7, 1, 0, 0);
      measure(st, ho);
      check("lu_stalls", 32'(st), FWD ? 1 : NSTAGE);
      check("lu_sel1", 32'(src1_sel_o), FWD ? 2 : 0);
      check("lu_sel2", 32'(src2_sel_o), FWD ? 2 : 0);
      drain();

      // ---------------- youngest producer wins ----------------
      decode(1, 1, 5'd3, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      decode(1, 1, 5'd3, 5'd0, 0, 5'd0, 0, 0, 0);
      #1;
      check("prio_2nd_stall", 32'(stall_o), 0);
      tick();
      decode(1, 1, 5'd4, 5'd3, 1, 5'd0, 0, 0, 0);
      measure(st, ho);
      check("prio_stalls", 32'(st), FWD ? 0 : NSTAGE);
      check("prio_sel1", 32'(src1_sel_o), FWD ? 1 : 0);
      drain();

      // ---------------- x0 never matches ----------------
      decode(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
      tick();
      decode(1, 1, 5'd4, 5'd0, 1, 5'd0, 1, 0, 0);
      #1;
      check("x0_stall", 32'(stall_o), 0);
      check("x0_sel1", 32'(src1_sel_o), 0);
      check("x0_sel2", 32'(src2_sel_o), 0);
      drain();

      // ---------------- M/D hold with independent follower ----------------
      decode(1, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 1);
      #1;
      check("md_pre_hold", 32'(hold_e_o), 0);
      tick();
      check("md_busy_first", 32'(busy_o), 1);
      check("md_hold_first", 32'(hold_e_o), 1);
      decode(1, 1, 5'd10, 5'd1, 1, 5'd2, 1, 0, 0);
      measure(st, ho);
      check("md_indep_stalls", 32'(st), MD_LAT - 1);
      check("md_hold_cycles", 32'(ho), MD_LAT - 1);
      check("md_hold_end", 32'(hold_e_o), 0);
      check("md_busy_end", 32'(busy_o), 0);
      drain();

      // ---------------- M/D with dependent follower ----------------
      decode(1, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 1);
      tick();
      decode(1, 1, 5'd11, 5'd9, 1, 5'd0, 0, 0, 0);
      measure(st, ho);
      check("md_dep_stalls", 32'(st), FWD ? MD_LAT - 1 : MD_LAT - 1 + NSTAGE);
      check("md_dep_sel1", 32'(src1_sel_o), FWD ? 1 : 0);
      drain();

      // ---------------- reset during M/D hold ----------------
      decode(1, 1, 5'd9, 5'd0, 0, 5'd0, 0, 0, 1);
      tick();
      idle();
      tick();
      check("md_rst_busy_before", 32'(busy_o), 1);
      #2;
      resetn = 1'b0;
      #1;
      check("md_rst_busy", 32'(busy_o), 0);
      check("md_rst_hold", 32'(hold_e_o), 0);
      #2;
      resetn = 1'b1;
      tick();
      decode(1, 1, 5'd11, 5'd9, 1, 5'd0, 0, 0, 0);
      #1;
      check("md_rst_cleared_stall", 32'(stall_o), 0);
      check("md_rst_cleared_sel1", 32'(src1_sel_o), 0);
      drain();

      // ---------------- flush kills decode ----------------
      decode(1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      decode(1, 1, 5'd6, 5'd5, 1, 5'd0, 0, 0, 0);
      #1;
      check("flush_sel1", 32'(src1_sel_o), 0);
      check("flush_stall", 32'(stall_o), 0);
      drain();

      // ---------------- flush together with stall ----------------
      decode(1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 1, 0);
      tick();
      decode(1, 1, 5'd8, 5'd7, 1, 5'd0, 0, 0, 0);
      flush_i = 1'b1;
      #1;
      check("flush_stall_kept", 32'(stall_o), 1);
      tick();
      flush_i = 1'b0;
      #1;
      check("flush_after_stall", 32'(stall_o), FWD ? 0 : 1);
      check("flush_after_sel1", 32'(src1_sel_o), FWD ? 2 : 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard and bypass-control unit for the in-order MCU pipeline, successor to the fixed five-stage hazard logic. It tracks in-flight destination registers across a configurable number of post-decode stages and selects the bypass source for each decode operand. It stalls decode on load-use and unresolved dependencies, and holds the pipeline for a multi-cycle multiply/divide unit with configurable latency. It sits beside the ID stage and drives the decode stall, the operand select lines and the EXE hold.

## Interface
- NSTAGE, 3: post-decode stages tracked; stage 1 = EXE, stage NSTAGE = WB; legal range 2..6
- LOAD_STG, 2: first stage whose output carries load data; legal range 2..NSTAGE
- MD_LAT, 4: cycles an M/D op occupies stage 1, including its first cycle; legal range 1..64
- SW (derived), $clog2(NSTAGE+1): select width

Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `resetn`).

- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decode holds a valid instruction
- dst_en_i  in  1  decoded instruction writes rd
- rd_i  in  5  decoded destination index
- rs1_i, rs2_i  in  5 each  decoded source indices
- rs1_en_i, rs2_en_i  in  1 each  source actually read
- is_load_i  in  1  decoded instruction is a load
- is_md_i  in  1  decoded instruction is multiply/divide
- flush_i  in  1  redirect from EXE; kills the decode instruction
- stall_o  out  1  hold fetch/decode this cycle
- src1_sel_o, src2_sel_o  out  SW each  0 = regfile, k = bypass from stage k output
- hold_e_o  out  1  M/D op occupying stage 1; EXE register must not advance
- busy_o  out  1  M/D counter non-zero

## Operation
- Each stage entry holds: valid, rd, dst_en, is_load, is_md.
- Match for source s at stage k: rs_en, valid, dst_en, rd == s, and s != 0. The youngest match (lowest k) wins.
- Operand select:
  - No match: select 0.
  - Youngest match usable (not a load, or k >= LOAD_STG): select k.
  - Youngest match is a load with k < LOAD_STG: stall.
  - Youngest match is at stage 1 while hold_e_o: stall.
- stall_o = any operand stall | (issue_valid_i & hold_e_o & ~last M/D cycle).
- Issue accepted = issue_valid_i & ~stall_o & ~flush_i. An accepted instruction enters stage 1. Otherwise a bubble enters stage 1, except during hold.
- Stages 2..NSTAGE shift every cycle. During hold, a bubble enters stage 2 and stage 1 keeps its entry.
- M/D op:
  - When an is_md entry enters stage 1, the counter loads MD_LAT-1.
  - While the counter is non-zero: hold_e_o = busy_o = 1, and the counter decrements each cycle.
  - When the counter reaches 0, the entry advances on the next edge.
  - MD_LAT = 1 means no hold.
- flush_i never removes entries already in stages 1..NSTAGE and never cancels an M/D countdown.
- Simultaneous flush_i and stall_o: flush wins, a bubble is inserted, and stall_o stays as computed.

## Timing
- stall_o, src*_sel_o and hold_e_o are combinational from current state and decode inputs. State updates on the rising clk edge.
- Asynchronous reset clears all entries and the counter. Outputs after reset: stall_o = 0, src*_sel_o = 0, hold_e_o = 0, busy_o = 0.
- Reset asserted mid-M/D aborts the countdown immediately.
- Producer-to-consumer spacing:
  - Back-to-back: select 1, zero stall.
  - Load then use with LOAD_STG = 2: one stall cycle, then select 2.
- An entry leaving stage NSTAGE is visible in the regfile the same cycle (write-through regfile), so no match is needed.

## Configuration
- SCB_FWD_EN defined: full bypass as above.
- SCB_FWD_EN undefined:
  - src*_sel_o is tied to 0.
  - Any match in stages 1..NSTAGE stalls decode until the producer has left stage NSTAGE.
  - M/D hold is unchanged.

## Test plan
- Reset: hold resetn low 3 cycles with random inputs -> all outputs 0. Release, issue `add x5`, then `sub x6,x5,x1` next cycle -> src1_sel_o = 1, stall_o = 0.
- Spacing: `add x5`, nop, use x5 -> src1_sel_o = 2. Three bubbles later -> src1_sel_o = 0.
- Load-use (LOAD_STG = 2): `lw x7`, then `add x8,x7,x7` -> stall_o = 1 for 1 cycle, then src1_sel_o = src2_sel_o = 2.
- Priority and x0: `add x3`, `add x3`, use x3 -> src1_sel_o = 1. A write to x0 followed by a read of x0 -> src1_sel_o = 0, no stall.
- M/D (MD_LAT = 4): `div x9` -> hold_e_o = busy_o = 1 for 3 cycles. A following independent issue stalls 3 cycles. A consumer of x9 then gets src1_sel_o = 1. Reset asserted at cycle 2 of the hold -> busy_o = 0 immediately.
- Flush and no-forward: flush_i with issue_valid_i -> next cycle stage 1 is empty (a consumer sees sel 0). With SCB_FWD_EN undefined and NSTAGE = 3, a back-to-back RAW pair -> 3 stall cycles, then sel 0.
